// File: rtl/cic_dec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cic_dec_ctrl_pkg
// Shared definitions for the CIC decimator control slice: the control FSM
// state encoding and the smallest decimation ratio the chain supports.
// ---------------------------------------------------------------------------
package cic_dec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Ratios below this cannot decimate and are rejected with cfg_err.
    localparam int unsigned MIN_RATIO = 2;

endpackage

// File: rtl/cic_dec_ctrl_dly.sv
// ---------------------------------------------------------------------------
// ctrl_dly
// N-deep single-bit shift register carrying decimation tokens alongside the
// integrator pipeline. A synchronous flush empties every stage at once.
//
// Ports:
//   clk   - rising-edge clock
//   flush - synchronous clear of all stages (wins over shifting)
//   din   - token entering stage 0
//   dout  - token leaving stage N-1
// ---------------------------------------------------------------------------
module ctrl_dly #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [N-1:0] tok_p;

    always_ff @(posedge clk) begin
        if (flush) begin
            tok_p <= '0;
        end else begin
            tok_p[0] <= din;
            for (int i = 1; i < N; i++) begin
                tok_p[i] <= tok_p[i-1];
            end
        end
    end

    assign dout = tok_p[N-1];

endmodule

// File: rtl/cic_dec_ctrl.sv
// ---------------------------------------------------------------------------
// cic_dec_ctrl
// Control for a CIC decimator: accepts a decimation ratio, clears the
// integrator chain for N+1 cycles, then drives the integrator enable from
// the sample strobe and emits one comb strobe per R samples, aligned to the
// integrator output (N+1 cycles after the launching sample).
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cfg_val/cfg_ratio - configuration request and ratio R (legal 2..2^RW-1)
//   cfg_rdy           - configuration can be accepted (IDLE or RUN)
//   cfg_err           - one-cycle pulse after an illegal ratio is offered
//   val_in            - source sample strobe
//   int_en, int_rst   - integrator chain enable and clear
//   dec_val           - comb-section strobe
//   phase             - current decimation phase 0..R-1
//   busy              - high in CLEAR or RUN
// ---------------------------------------------------------------------------
module cic_dec_ctrl
    import cic_dec_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_val,
    input  logic [RW-1:0] cfg_ratio,
    output logic          cfg_rdy,
    output logic          cfg_err,
    input  logic          val_in,
    output logic          int_en,
    output logic          int_rst,
    output logic          dec_val,
    output logic [RW-1:0] phase,
    output logic          busy
);

    localparam int CW = $clog2(N + 1) + 1;

    state_t        state, state_nxt;
    logic [RW-1:0] ratio_q;
    logic [RW-1:0] phase_q;
    logic [RW-1:0] last_phase;
    logic [CW-1:0] clr_cnt;
    logic          cfg_hit;
    logic          cfg_ok;
    logic          cfg_bad;
    logic          clr_done;
    logic          in_run;
    logic          tok_p0;
    logic          tok_pn;
    logic          dly_flush;

    // cfg_rdy depends on state only, so acceptance never loops back on itself.
    assign cfg_rdy  = (state != ST_CLEAR);
    assign cfg_hit  = cfg_val && cfg_rdy;
    assign cfg_ok   = cfg_hit && (cfg_ratio >= RW'(MIN_RATIO));
    assign cfg_bad  = cfg_hit && (cfg_ratio <  RW'(MIN_RATIO));
    assign clr_done = (clr_cnt == CW'(N));
    assign in_run   = (state == ST_RUN);

    // R-1 is formed at RW bits so R = 2^RW-1 compares without overflow.
    assign last_phase = ratio_q - RW'(1);

    // A sample arriving with a reconfiguration is not counted.
    assign tok_p0 = in_run && val_in && !cfg_ok && (phase_q == last_phase);

    // In-flight tokens die on reset, on any accepted reconfiguration and
    // throughout CLEAR.
    assign dly_flush = rst || cfg_ok || (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        int_rst   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (cfg_ok) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy    = 1'b1;
                int_rst = 1'b0;
                if (cfg_ok) state_nxt = ST_CLEAR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ratio_q <= RW'(MIN_RATIO);
            phase_q <= '0;
            clr_cnt <= '0;
            int_en  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_bad;
            int_en  <= in_run && val_in && !cfg_ok;
            if (cfg_ok) begin
                ratio_q <= cfg_ratio;
                phase_q <= '0;
                clr_cnt <= '0;
            end else begin
                if (state == ST_CLEAR) begin
                    clr_cnt <= clr_cnt + CW'(1);
                end
                if (in_run && val_in) begin
                    phase_q <= tok_p0 ? '0 : phase_q + RW'(1);
                end
            end
        end
    end

    // Token path: N delay stages plus this output register = N+1 cycles,
    // matching int_en (1 cycle) followed by N integrator stages.
    ctrl_dly #(
        .N(N)
    ) u_dly (
        .clk  (clk),
        .flush(dly_flush),
        .din  (tok_p0),
        .dout (tok_pn)
    );

    always_ff @(posedge clk) begin
        if (dly_flush) begin
            dec_val <= 1'b0;
        end else begin
            dec_val <= tok_pn;
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
module tb_cic_dec_ctrl;

    localparam int N  = 3;
    localparam int RW = 8;

    logic          clk;
    logic          rst;
    logic          cfg_val;
    logic [RW-1:0] cfg_ratio;
    logic          cfg_rdy;
    logic          cfg_err;
    logic          val_in;
    logic          int_en;
    logic          int_rst;
    logic          dec_val;
    logic [RW-1:0] phase;
    logic          busy;

    int total;
    int passed;
    int nsamp;
    int pulses;

    cic_dec_ctrl #(.N(N), .RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_val  (cfg_val),
        .cfg_ratio(cfg_ratio),
        .cfg_rdy  (cfg_rdy),
        .cfg_err  (cfg_err),
        .val_in   (val_in),
        .int_en   (int_en),
        .int_rst  (int_rst),
        .dec_val  (dec_val),
        .phase    (phase),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Offer a ratio, then walk the N+1 CLEAR cycles and land in RUN.
    // With hold set, cfg_val stays high through CLEAR.
    task automatic cfg_and_clear(input logic [RW-1:0] r, input bit hold);
        cfg_val   = 1'b1;
        cfg_ratio = r;
        tick();
        if (!hold) cfg_val = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            chk("clr_int_rst", int_rst, 1);
            chk("clr_cfg_rdy", cfg_rdy, 0);
            chk("clr_busy",    busy,    1);
            chk("clr_int_en",  int_en,  0);
            chk("clr_phase",   phase,   0);
            chk("clr_dec_val", dec_val, 0);
            tick();
        end
        chk("run_int_rst", int_rst, 0);
        chk("run_cfg_rdy", cfg_rdy, 1);
        chk("run_busy",    busy,    1);
        chk("run_int_en",  int_en,  0);
        cfg_val = 1'b0;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        rst       = 1'b1;
        cfg_val   = 1'b0;
        cfg_ratio = '0;
        val_in    = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_cfg_rdy", cfg_rdy, 1);
        chk("rst_busy",    busy,    0);
        chk("rst_int_rst", int_rst, 1);
        chk("rst_int_en",  int_en,  0);
        chk("rst_dec_val", dec_val, 0);
        chk("rst_phase",   phase,   0);
        chk("rst_cfg_err", cfg_err, 0);

        // R=4, 16 continuous samples: pulses observed at ticks 7,11,15,19
        cfg_and_clear(8'd4, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            val_in = (i <= 16);
            tick();
            chk("cont_int_en",  int_en,  (i <= 16));
            chk("cont_phase",   phase,   ((i <= 16) ? i : 16) % 4);
            chk("cont_dec_val", dec_val, (i == 7 || i == 11 || i == 15 || i == 19));
            if (dec_val) pulses++;
        end
        chk("cont_pulses", pulses, 4);

        // R=4, sample every 3rd cycle: samples 4 and 8 at ticks 10 and 22
        nsamp  = 0;
        pulses = 0;
        for (int i = 1; i <= 26; i++) begin
            val_in = ((i - 1) % 3 == 0) && (i <= 22);
            tick();
            if (val_in) nsamp++;
            chk("gap_int_en",  int_en,  val_in);
            chk("gap_phase",   phase,   nsamp % 4);
            chk("gap_dec_val", dec_val, (i == 13 || i == 25));
            if (dec_val) pulses++;
        end
        val_in = 1'b0;
        chk("gap_pulses", pulses, 2);

        // Illegal ratios in IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_val   = 1'b1;
        cfg_ratio = 8'd1;
        tick();
        chk("err1_cfg_err", cfg_err, 1);
        chk("err1_busy",    busy,    0);
        chk("err1_cfg_rdy", cfg_rdy, 1);
        cfg_val = 1'b0;
        tick();
        chk("err1_pulse_end", cfg_err, 0);
        chk("err1_busy2",     busy,    0);
        cfg_val   = 1'b1;
        cfg_ratio = 8'd0;
        tick();
        chk("err0_cfg_err", cfg_err, 1);
        chk("err0_busy",    busy,    0);
        cfg_val = 1'b0;
        tick();
        chk("err0_pulse_end", cfg_err, 0);

        // R=4 accepted, cfg_val held through CLEAR
        cfg_and_clear(8'd4, 1'b1);

        // 10 samples -> phase 2; pulse from sample 4 at tick 7
        for (int i = 1; i <= 10; i++) begin
            val_in = 1'b1;
            tick();
            chk("pre_phase",   phase,   i % 4);
            chk("pre_dec_val", dec_val, (i == 7));
        end
        chk("pre_phase2", phase, 2);

        // Reconfigure to R=5 with a sample in the same cycle; sample-8 token
        // would have surfaced on the accept edge
        cfg_and_clear(8'd5, 1'b0);
        pulses = 0;
        for (int j = 1; j <= 14; j++) begin
            val_in = (j <= 10);
            tick();
            chk("r5_phase",   phase,   ((j <= 10) ? j : 10) % 5);
            chk("r5_dec_val", dec_val, (j == 8 || j == 13));
            if (dec_val) pulses++;
        end
        chk("r5_pulses", pulses, 2);

        // Reset with a token in flight (would surface at tick 8)
        for (int j = 1; j <= 5; j++) begin
            val_in = 1'b1;
            tick();
            chk("fl_dec_val", dec_val, 0);
        end
        val_in = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",    busy,    0);
        chk("mid_rst_int_rst", int_rst, 1);
        chk("mid_rst_cfg_rdy", cfg_rdy, 1);
        chk("mid_rst_phase",   phase,   0);
        chk("mid_rst_dec_val", dec_val, 0);
        for (int j = 7; j <= 10; j++) begin
            val_in = 1'b1;
            tick();
            chk("idle_dec_val", dec_val, 0);
            chk("idle_int_en",  int_en,  0);
            chk("idle_phase",   phase,   0);
        end
        val_in = 1'b0;

        // Largest ratio: R=255
        cfg_and_clear(8'd255, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 260; i++) begin
            val_in = (i <= 255);
            tick();
            if (i == 254) chk("max_phase254", phase, 254);
            if (i == 255) chk("max_wrap",     phase, 0);
            if (i == 258) chk("max_dec_val",  dec_val, 1);
            if (dec_val) pulses++;
        end
        chk("max_pulses", pulses, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
